sonic_circbuf_addr_gen: RTL and testbench
=========================================

Name: sonic_circbuf_addr_gen

Overview:
- Parametrised, multi-channel circular-buffer address engine for the TX and RX DMA paths.
- Each channel has a write (producer) pointer, a read (consumer) pointer, an occupancy level and full/empty flags.
- Each pointer advances by a variable step, wraps at a runtime-programmable last index, and is translated to a physical address in the channel's own region of a shared buffer RAM.
- Overflow and underflow are caught as sticky errors; an illegal advance never corrupts a pointer.

Parameters:
- NUM_CH, 2, number of independent channels.
- ADDR_W, 14, physical address width of the shared buffer RAM.
- CH_DEPTH, 7936 (0x1F00), maximum entries per channel. Requires NUM_CH*CH_DEPTH <= 2**ADDR_W (elaboration assertion).
- STEP_W, 4, width of the step inputs; maximum step is 15 entries.

Ports:
- clk_in  in  1  clock.
- reset  in  1  reset.
- ena  in  1  global enable; when low, all advances are ignored with no error.
- clear  in  NUM_CH  per-channel synchronous clear; also latches cfg_last.
- cfg_last  in  ADDR_W  last valid index, sampled on clear.
- wr_adv  in  NUM_CH  request to advance the write pointer.
- wr_step  in  NUM_CH*STEP_W  write step per channel.
- rd_adv  in  NUM_CH  request to advance the read pointer.
- rd_step  in  NUM_CH*STEP_W  read step per channel.
- wr_addr  out  NUM_CH*ADDR_W  physical write address, registered.
- rd_addr  out  NUM_CH*ADDR_W  physical read address, registered.
- level  out  NUM_CH*(ADDR_W+1)  occupied entries.
- full  out  NUM_CH  level equals effective depth.
- empty  out  NUM_CH  level equals 0.
- ovf_err  out  NUM_CH  sticky: write advance rejected.
- unf_err  out  NUM_CH  sticky: read advance rejected.

Behaviour:
- Reset (already decided): reset, asynchronous, active-high; clock clk_in.
- Reset values:
  - pointers = 0, level = 0.
  - last_c = CH_DEPTH-1.
  - wr_addr_c = rd_addr_c = c*CH_DEPTH.
  - empty = all 1, full = 0, errors = 0.
- Effective depth D_c = last_c+1.
- Clear (synchronous, per channel):
  - Sets pointers, level and both error bits of channel c to 0.
  - Latches last_c = min(cfg_last, CH_DEPTH-1).
  - Has priority over any advance in the same cycle; that advance is dropped with no error.
- Write advance accept: ena & wr_adv_c & wr_step_c != 0 & (level_c + wr_step_c <= D_c).
- Read advance accept: ena & rd_adv_c & rd_step_c != 0 & (level_c >= rd_step_c).
- A step of 0 is a no-op with no error.
- Rejected advance: pointer and level unchanged; the corresponding sticky error bit is set, held until clear or reset.
- Simultaneous read and write on one channel:
  - Both acceptance checks use the pre-edge level.
  - level_next = level + (wr accepted ? wr_step : 0) - (rd accepted ? rd_step : 0).
  - Consequence: a write into a full buffer is rejected even if a read is accepted in the same cycle.
- Wrap arithmetic: sum = ptr + step, computed at ADDR_W+1 bits; ptr_next = (sum > last_c) ? sum - D_c : sum. This is a single subtraction, legal because step <= 15 < D_c. cfg_last < 15 is unsupported and must be rejected by a bench assertion.
- Wrap happens only when a pointer advances. An idle pointer parked at last_c stays there.
- Address mapping: wr_addr_c = c*CH_DEPTH + wr_ptr_c, likewise rd_addr_c. Both are registered from the next-pointer value, so the output reflects the new pointer on the same edge that updates it (1-cycle latency from request to new address).
- full and empty are combinational from registered level and last_c.
- Channels are fully independent; no cross-channel arbitration.

Decomposition:
- Package sonic_circbuf_pkg holds:
  - localparams for default ADDR_W, CH_DEPTH and STEP_W.
  - function ch_base(c) returning c*CH_DEPTH.
  - typedef ptr_t = logic [ADDR_W-1:0] and lvl_t = logic [ADDR_W:0].
- Sub-module sonic_circbuf_ptr_ch implements one channel: pointers, level, wrap, errors, clear. The top instantiates it NUM_CH times in a generate loop, adds the base offsets and registers the addresses.

Test Plan:
- Reset, then write 4 steps of 1 on ch1 → wr_addr1 = 0x1F00, 0x1F01, 0x1F02, 0x1F03, 0x1F04; level1 = 4; ch0 unaffected.
- Clear ch0 with cfg_last = 31; write 30 + step 3 → third advance rejected (level 30 + 3 > 32); ovf_err0 = 1; pointer stays at 30.
- With last = 31: read to level 2, write ptr at 30, write step 4 → wr_ptr wraps to 2, wr_addr0 = 0x0002, level = 6.
- Level 8, same cycle write step 5 and read step 8 → both accepted; level = 5; empty = 0.
- Empty channel, read step 1 → unf_err = 1, rd_ptr unchanged. Then clear asserted together with wr_adv → error cleared, write dropped, level = 0.
- Pulse reset asynchronously mid-burst with ena high → all outputs reach reset values before the next edge; the first post-reset advance starts from the channel base address.

Source files
------------

// File: rtl/sonic_circbuf_pkg.sv
// Shared constants, types and helpers for the sonic circular-buffer address engine.
package sonic_circbuf_pkg;

  localparam int ADDR_W_DEF   = 14;
  localparam int CH_DEPTH_DEF = 7936;
  localparam int STEP_W_DEF   = 4;

  typedef logic [ADDR_W_DEF-1:0] ptr_t;
  typedef logic [ADDR_W_DEF:0]   lvl_t;

  function automatic int unsigned ch_base(input int unsigned c,
                                          input int unsigned depth = CH_DEPTH_DEF);
    return c * depth;
  endfunction

endpackage

// File: rtl/sonic_circbuf_ptr_ch.sv
// One circular-buffer channel: write/read pointers with wrap, occupancy level,
// sticky overflow/underflow flags and a synchronous clear that reloads the last index.
module sonic_circbuf_ptr_ch
  import sonic_circbuf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CH_DEPTH = CH_DEPTH_DEF,
  parameter int STEP_W   = STEP_W_DEF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              ena,
  input  logic              clear,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic              wr_adv,
  input  logic [STEP_W-1:0] wr_step,
  input  logic              rd_adv,
  input  logic [STEP_W-1:0] rd_step,
  output logic [ADDR_W-1:0] wr_ptr_nxt,
  output logic [ADDR_W-1:0] rd_ptr_nxt,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(CH_DEPTH - 1);
  localparam int                PAD      = ADDR_W + 1 - STEP_W;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, last_q, last_d;
  logic [ADDR_W:0]   level_q, level_d, depth_s, wr_step_x, rd_step_x;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              wr_req_s, rd_req_s, wr_ok_s, rd_ok_s;

  // A single conditional subtraction suffices because a step never exceeds the depth.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] ptr,
                                                 input logic [ADDR_W:0]   step,
                                                 input logic [ADDR_W-1:0] last,
                                                 input logic [ADDR_W:0]   depth);
    logic [ADDR_W:0] sum;
    logic [ADDR_W:0] res;
    sum = {1'b0, ptr} + step;
    res = (sum > {1'b0, last}) ? (sum - depth) : sum;
    return res[ADDR_W-1:0];
  endfunction

  // Next-state: acceptance checks both use the pre-edge level; clear overrides any advance.
  always_comb begin
    depth_s   = {1'b0, last_q} + {{ADDR_W{1'b0}}, 1'b1};
    wr_step_x = {{PAD{1'b0}}, wr_step};
    rd_step_x = {{PAD{1'b0}}, rd_step};
    wr_req_s  = ena & wr_adv & (wr_step != {STEP_W{1'b0}});
    rd_req_s  = ena & rd_adv & (rd_step != {STEP_W{1'b0}});
    wr_ok_s   = wr_req_s & ((level_q + wr_step_x) <= depth_s);
    rd_ok_s   = rd_req_s & (level_q >= rd_step_x);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    last_d    = last_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (clear) begin
      wr_ptr_d = {ADDR_W{1'b0}};
      rd_ptr_d = {ADDR_W{1'b0}};
      level_d  = {(ADDR_W+1){1'b0}};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      last_d   = (cfg_last > LAST_MAX) ? LAST_MAX : cfg_last;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_d = wrap_add(wr_ptr_q, wr_step_x, last_q, depth_s);
      end else begin
        ovf_d = ovf_q | wr_req_s;
      end
      if (rd_ok_s) begin
        rd_ptr_d = wrap_add(rd_ptr_q, rd_step_x, last_q, depth_s);
      end else begin
        unf_d = unf_q | rd_req_s;
      end
      level_d = level_q
              + (wr_ok_s ? wr_step_x : {(ADDR_W+1){1'b0}})
              - (rd_ok_s ? rd_step_x : {(ADDR_W+1){1'b0}});
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      level_q  <= {(ADDR_W+1){1'b0}};
      last_q   <= LAST_MAX;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_ptr_nxt = wr_ptr_d;
  assign rd_ptr_nxt = rd_ptr_d;
  assign level      = level_q;
  assign full       = (level_q == depth_s);
  assign empty      = (level_q == {(ADDR_W+1){1'b0}});
  assign ovf_err    = ovf_q;
  assign unf_err    = unf_q;

endmodule

// File: rtl/sonic_circbuf_addr_gen.sv
// Multi-channel circular-buffer address engine: one pointer engine per channel,
// each mapped into its own region of the shared buffer RAM with registered addresses.
module sonic_circbuf_addr_gen
  import sonic_circbuf_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CH_DEPTH = CH_DEPTH_DEF,
  parameter int STEP_W   = STEP_W_DEF
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         ena,
  input  logic [NUM_CH-1:0]            clear,
  input  logic [ADDR_W-1:0]            cfg_last,
  input  logic [NUM_CH-1:0]            wr_adv,
  input  logic [NUM_CH*STEP_W-1:0]     wr_step,
  input  logic [NUM_CH-1:0]            rd_adv,
  input  logic [NUM_CH*STEP_W-1:0]     rd_step,
  output logic [NUM_CH*ADDR_W-1:0]     wr_addr,
  output logic [NUM_CH*ADDR_W-1:0]     rd_addr,
  output logic [NUM_CH*(ADDR_W+1)-1:0] level,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH-1:0]            ovf_err,
  output logic [NUM_CH-1:0]            unf_err
);

  if (NUM_CH * CH_DEPTH > (1 << ADDR_W)) begin : g_cfg_err
    $error("sonic_circbuf_addr_gen: NUM_CH*CH_DEPTH exceeds the buffer address space");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ch_base(int'(c), CH_DEPTH));

    logic [ADDR_W-1:0] wr_nxt_s, rd_nxt_s;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;

    sonic_circbuf_ptr_ch #(
      .ADDR_W   (ADDR_W),
      .CH_DEPTH (CH_DEPTH),
      .STEP_W   (STEP_W)
    ) u_ch (
      .clk_in     (clk_in),
      .reset      (reset),
      .ena        (ena),
      .clear      (clear[c]),
      .cfg_last   (cfg_last),
      .wr_adv     (wr_adv[c]),
      .wr_step    (wr_step[c*STEP_W +: STEP_W]),
      .rd_adv     (rd_adv[c]),
      .rd_step    (rd_step[c*STEP_W +: STEP_W]),
      .wr_ptr_nxt (wr_nxt_s),
      .rd_ptr_nxt (rd_nxt_s),
      .level      (level[c*(ADDR_W+1) +: (ADDR_W+1)]),
      .full       (full[c]),
      .empty      (empty[c]),
      .ovf_err    (ovf_err[c]),
      .unf_err    (unf_err[c])
    );

    // Physical address from the next pointer so it lands on the same edge as the pointer.
    always_comb begin
      wr_addr_d = BASE + wr_nxt_s;
      rd_addr_d = BASE + rd_nxt_s;
    end

    // Address output registers.
    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        wr_addr_q <= BASE;
        rd_addr_q <= BASE;
      end else begin
        wr_addr_q <= wr_addr_d;
        rd_addr_q <= rd_addr_d;
      end
    end

    assign wr_addr[c*ADDR_W +: ADDR_W] = wr_addr_q;
    assign rd_addr[c*ADDR_W +: ADDR_W] = rd_addr_q;
  end

endmodule

// File: tb/tb_sonic_circbuf_addr_gen.sv
// Self-checking bench for sonic_circbuf_addr_gen: vector table with scoreboard queue,
// plus hand sequences for last-index clamping, parked pointers and asynchronous reset.
module tb_sonic_circbuf_addr_gen;

  logic        clk_in;
  logic        reset;
  logic        ena;
  logic [1:0]  clear;
  logic [13:0] cfg_last;
  logic [1:0]  wr_adv;
  logic [7:0]  wr_step;
  logic [1:0]  rd_adv;
  logic [7:0]  rd_step;
  logic [27:0] wr_addr;
  logic [27:0] rd_addr;
  logic [29:0] level;
  logic [1:0]  full;
  logic [1:0]  empty;
  logic [1:0]  ovf_err;
  logic [1:0]  unf_err;

  int nerr = 0;
  int nchk = 0;

  sonic_circbuf_addr_gen dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .ena      (ena),
    .clear    (clear),
    .cfg_last (cfg_last),
    .wr_adv   (wr_adv),
    .wr_step  (wr_step),
    .rd_adv   (rd_adv),
    .rd_step  (rd_step),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .ovf_err  (ovf_err),
    .unf_err  (unf_err)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) begin
    if (!reset && (|clear)) begin
      assert (cfg_last >= 14'd15) else $error("cfg_last below 15 is unsupported");
    end
  end

  typedef struct {
    string       name;
    int          ch;
    bit          clr;
    logic [13:0] last;
    bit          en;
    bit          wa;
    logic [3:0]  ws;
    bit          ra;
    logic [3:0]  rs;
    int          e_wa;
    int          e_ra;
    int          e_lvl;
    bit          e_full;
    bit          e_empty;
    bit          e_ovf;
    bit          e_unf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string n, int ch, bit clr, int last, bit en,
                              bit wa, int ws, bit ra, int rs,
                              int e_wa, int e_ra, int e_lvl,
                              bit f, bit e, bit o, bit u);
    vec_t v;
    v.name = n;    v.ch = ch;     v.clr = clr;   v.last = 14'(last);
    v.en = en;     v.wa = wa;     v.ws = 4'(ws); v.ra = ra; v.rs = 4'(rs);
    v.e_wa = e_wa; v.e_ra = e_ra; v.e_lvl = e_lvl;
    v.e_full = f;  v.e_empty = e; v.e_ovf = o;   v.e_unf = u;
    return v;
  endfunction

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic check_ch(input string n, input int ch, input int e_wa, input int e_ra,
                          input int e_lvl, input bit f, input bit e, input bit o, input bit u);
    cmp({n, ".wr_addr"}, 32'(wr_addr[ch*14 +: 14]), e_wa);
    cmp({n, ".rd_addr"}, 32'(rd_addr[ch*14 +: 14]), e_ra);
    cmp({n, ".level"},   32'(level[ch*15 +: 15]),   e_lvl);
    cmp({n, ".full"},    32'(full[ch]),    32'(f));
    cmp({n, ".empty"},   32'(empty[ch]),   32'(e));
    cmp({n, ".ovf"},     32'(ovf_err[ch]), 32'(o));
    cmp({n, ".unf"},     32'(unf_err[ch]), 32'(u));
  endtask

  task automatic check_reset_state(input string n);
    for (int c = 0; c < 2; c++) begin
      check_ch(n, c, c*7936, c*7936, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic idle_inputs();
    ena     = 1'b1;
    clear   = 2'b00;
    wr_adv  = 2'b00;
    rd_adv  = 2'b00;
    wr_step = 8'h00;
    rd_step = 8'h00;
  endtask

  // Drive one cycle on v.ch; expected record is queued at drive time and popped after the edge.
  task automatic apply(input vec_t v, input bit chk);
    vec_t e;
    @(negedge clk_in);
    idle_inputs();
    ena                    = v.en;
    cfg_last               = v.last;
    clear[v.ch]            = v.clr;
    wr_adv[v.ch]           = v.wa;
    wr_step[v.ch*4 +: 4]   = v.ws;
    rd_adv[v.ch]           = v.ra;
    rd_step[v.ch*4 +: 4]   = v.rs;
    if (chk) sb.push_back(v);
    @(posedge clk_in);
    #1;
    idle_inputs();
    if (chk) begin
      if (sb.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL scoreboard: got empty queue expected one record");
      end else begin
        e = sb.pop_front();
        check_ch(e.name, e.ch, e.e_wa, e.e_ra, e.e_lvl, e.e_full, e.e_empty, e.e_ovf, e.e_unf);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    cfg_last = 14'd31;
    idle_inputs();
    ena      = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_state("reset");
    @(negedge clk_in);
    reset = 1'b0;
    ena   = 1'b1;

    //             name         ch clr last en wa ws ra rs  e_wa  e_ra  lvl f e o u
    tbl.push_back(mk("ch1_wr1",  1, 0, 31, 1, 1, 1, 0, 0, 7937, 7936,  1, 0,0,0,0));
    tbl.push_back(mk("ch1_wr2",  1, 0, 31, 1, 1, 1, 0, 0, 7938, 7936,  2, 0,0,0,0));
    tbl.push_back(mk("ch1_wr3",  1, 0, 31, 1, 1, 1, 0, 0, 7939, 7936,  3, 0,0,0,0));
    tbl.push_back(mk("ch1_wr4",  1, 0, 31, 1, 1, 1, 0, 0, 7940, 7936,  4, 0,0,0,0));
    tbl.push_back(mk("ena_low",  1, 0, 31, 0, 1, 1, 1, 1, 7940, 7936,  4, 0,0,0,0));
    tbl.push_back(mk("step0",    1, 0, 31, 1, 1, 0, 1, 0, 7940, 7936,  4, 0,0,0,0));
    tbl.push_back(mk("clr31",    0, 1, 31, 1, 0, 0, 0, 0,    0,    0,  0, 0,1,0,0));
    tbl.push_back(mk("wr15a",    0, 0, 31, 1, 1,15, 0, 0,   15,    0, 15, 0,0,0,0));
    tbl.push_back(mk("wr15b",    0, 0, 31, 1, 1,15, 0, 0,   30,    0, 30, 0,0,0,0));
    tbl.push_back(mk("ovf3",     0, 0, 31, 1, 1, 3, 0, 0,   30,    0, 30, 0,0,1,0));
    tbl.push_back(mk("rd15",     0, 0, 31, 1, 0, 0, 1,15,   30,   15, 15, 0,0,1,0));
    tbl.push_back(mk("rd13",     0, 0, 31, 1, 0, 0, 1,13,   30,   28,  2, 0,0,1,0));
    tbl.push_back(mk("wrap4",    0, 0, 31, 1, 1, 4, 0, 0,    2,   28,  6, 0,0,1,0));
    tbl.push_back(mk("clr31b",   0, 1, 31, 1, 0, 0, 0, 0,    0,    0,  0, 0,1,0,0));
    tbl.push_back(mk("fill15a",  0, 0, 31, 1, 1,15, 0, 0,   15,    0, 15, 0,0,0,0));
    tbl.push_back(mk("fill15b",  0, 0, 31, 1, 1,15, 0, 0,   30,    0, 30, 0,0,0,0));
    tbl.push_back(mk("fill_wrap",0, 0, 31, 1, 1, 2, 0, 0,    0,    0, 32, 1,0,0,0));
    tbl.push_back(mk("full_wr_rd",0,0, 31, 1, 1, 1, 1, 1,    0,    1, 31, 0,0,1,0));
    tbl.push_back(mk("rd15b",    0, 0, 31, 1, 0, 0, 1,15,    0,   16, 16, 0,0,1,0));
    tbl.push_back(mk("rd8",      0, 0, 31, 1, 0, 0, 1, 8,    0,   24,  8, 0,0,1,0));
    tbl.push_back(mk("wr5_rd8",  0, 0, 31, 1, 1, 5, 1, 8,    5,    0,  5, 0,0,1,0));
    tbl.push_back(mk("rd5",      0, 0, 31, 1, 0, 0, 1, 5,    5,    5,  0, 0,1,1,0));
    tbl.push_back(mk("unf1",     0, 0, 31, 1, 0, 0, 1, 1,    5,    5,  0, 0,1,1,1));
    tbl.push_back(mk("clr_wr",   0, 1, 31, 1, 1, 3, 0, 0,    0,    0,  0, 0,1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], 1'b1);
    end
    check_ch("ch1_indep", 1, 7940, 7936, 4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Oversized last index clamps to CH_DEPTH-1; pointer parks at last, then wraps.
    apply(mk("clamp_clr", 1, 1, 16383, 1, 0, 0, 0, 0, 7936, 7936, 0, 0,1,0,0), 1'b1);
    apply(mk("", 1, 0, 31, 1, 1, 15, 0, 0, 0, 0, 0, 0,0,0,0), 1'b0);
    for (int k = 0; k < 528; k++) begin
      apply(mk("", 1, 0, 31, 1, 1, 15, 1, 15, 0, 0, 0, 0,0,0,0), 1'b0);
    end
    apply(mk("park",       1, 0, 31, 1, 0, 0, 0, 0, 15871, 15856, 15, 0,0,0,0), 1'b1);
    apply(mk("clamp_wrap", 1, 0, 31, 1, 1,15, 0, 0,  7950, 15856, 30, 0,0,0,0), 1'b1);

    // Asynchronous reset mid-burst, then the first advance restarts from each base.
    @(negedge clk_in);
    ena     = 1'b1;
    wr_adv  = 2'b11;
    wr_step = {4'd1, 4'd1};
    @(posedge clk_in);
    #1;
    #1 reset = 1'b1;
    #1 check_reset_state("async_rst");
    #1 reset = 1'b0;
    @(posedge clk_in);
    #1;
    check_ch("post_rst0", 0, 1,    0,    1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ch("post_rst1", 1, 7937, 7936, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
